rs_mul_div: RTL and testbench
=============================

// Module: rs_mul_div
// PURPOSE
//  Two-entry reservation station feeding the mul/div functional unit in the Tomasulo core.
//  Accepts issued MUL/DIV ops with operand values or producer tags and snoops the CDB for missing operands.
//  Dispatches one ready op at a time by holding the FU run/operand/opcode/dest/label lines stable until the FU signals done.
// PARAMETERS
//  DATA_W  9  operand width, matches the FU RegX/RegY width
//  TAG_W   3  CDB label / producer tag width
//  OP_W    3  opcode width; MUL=3'b010, DIV=3'b011
//  DEPTH   2  entries; legal values 1..4
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       synchronous, active-high
//  issue_valid  in   1       issue request this cycle
//  issue_ready  out  1       at least one FREE entry (registered state only)
//  issue_op     in   OP_W    opcode
//  issue_dest   in   3       destination register address
//  issue_label  in   TAG_W   tag this op will broadcast on the CDB
//  issue_vj/vk  in   DATA_W  operand values (valid when *_rdy=1)
//  issue_qj/qk  in   TAG_W   producer tags (valid when *_rdy=0)
//  issue_j_rdy/k_rdy in 1    operand value already available
//  cdb_valid    in   1       CDB broadcast this cycle
//  cdb_label    in   TAG_W   CDB tag
//  cdb_value    in   DATA_W  CDB data
//  fu_run       out  1       FU run request
//  fu_regx/regy out  DATA_W  operands to FU
//  fu_opcode    out  OP_W    opcode to FU
//  fu_addr      out  3       dest address to FU
//  fu_label     out  TAG_W   tag to FU
//  fu_done      in   1       FU result valid this cycle
//  illegal_op   out  1       1-cycle pulse: issue with opcode not MUL/DIV dropped
//  occupancy    out  3       number of non-FREE entries
// BEHAVIOUR
//  Reset: all entries FREE; fu_run=0, fu_regx/regy/opcode/addr/label=0, illegal_op=0, occupancy=0, issue_ready=1.
//  Entry FSM: FREE -> WAIT (issue, an operand missing) | READY (issue, both present);
//   WAIT -> READY when last missing tag matches CDB; READY -> EXEC on dispatch; EXEC -> FREE on fu_done.
//  Issue: accepted when issue_valid & issue_ready & op in {010,011}; fills lowest-index FREE entry.
//   Other opcodes: nothing written, illegal_op=1 next cycle. issue_valid with issue_ready=0: ignored, no pulse.
//  Same-cycle forwarding: if cdb_valid and cdb_label equals a missing issue_qj/qk, that value is captured at issue.
//  Wakeup: each WAIT entry compares qj and qk independently; both may resolve on one broadcast.
//  Dispatch: only when no entry is EXEC and fu_run=0; picks the oldest READY entry (age = issue order).
//   fu_run and all fu_* outputs are registered; they go valid the cycle after the dispatch decision.
//   These outputs are held constant until fu_done.
//  Done: on a cycle with fu_done=1 and fu_run=1, the EXEC entry becomes FREE and fu_run=0 next cycle.
//   fu_run stays low for at least 1 cycle between ops, so the FU counters restart cleanly.
//   fu_done while fu_run=0 is ignored.
//  Simultaneous events:
//   - A slot freed by fu_done cannot be reissued in the same cycle (issue_ready uses registered state).
//   - A CDB broadcast and an entry turning READY in the same cycle: dispatch occurs next cycle at the earliest.
//  Reset mid-operation: all entries drop and fu_run=0 next cycle. FU counter clearing is the system reset's job.
//  Widths: no arithmetic on data; tags compared at full TAG_W; occupancy saturates at DEPTH.
// CONFIGURATION
//  RS_DIV_ZERO_TRAP_EN defined:
//   - A DIV selected for dispatch with vk==0 is not sent to the FU; its entry goes READY -> FREE.
//   - div0_trap (out 1) pulses for 1 cycle, with div0_label (out TAG_W) set to the entry's tag.
//  Not defined: the div0 ports are absent and DIV with vk==0 is dispatched normally.
// TESTING
//  - Issue MUL vj=5 vk=7 (both ready), label=1, dest=2: fu_run=1 one cycle after acceptance, regx=5 regy=7 opcode=010 label=1.
//    Hold until fu_done; fu_run=0 next cycle.
//  - Issue DIV qj=3 (not ready) vk=4: stays WAIT. Then cdb_valid label=3 value=20: dispatch with regx=20 regy=4.
//  - Forwarding: issue with qj=5 while cdb_valid label=5 value=9 in the same cycle: entry READY and regx=9.
//  - Fill both entries (DEPTH=2): issue_ready=0; a 3rd issue is ignored. After fu_done, issue_ready=1 next cycle.
//    The oldest READY entry dispatches first.
//  - Issue opcode 3'b000: illegal_op pulses once and occupancy is unchanged.
//    Assert reset during EXEC: next cycle fu_run=0 and occupancy=0.
//  - With RS_DIV_ZERO_TRAP_EN: DIV vk=0 label=6 gives div0_trap=1 with div0_label=6, fu_run never asserts, entry FREE.

Source files
------------

// File: rtl/rs_mul_div.sv
// Two-entry (DEPTH) reservation station in front of the mul/div FU: tag wakeup from the CDB, oldest-ready dispatch.
// Optional RS_DIV_ZERO_TRAP_EN: a DIV with zero divisor is retired with a div0_trap pulse instead of dispatching.
module rs_mul_div #(
   parameter int DATA_W = 9,
   parameter int TAG_W  = 3,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_issue_valid,
   output logic              o_issue_ready,
   input  logic [OP_W-1:0]   i_issue_op,
   input  logic [2:0]        i_issue_dest,
   input  logic [TAG_W-1:0]  i_issue_label,
   input  logic [DATA_W-1:0] i_issue_vj,
   input  logic [DATA_W-1:0] i_issue_vk,
   input  logic [TAG_W-1:0]  i_issue_qj,
   input  logic [TAG_W-1:0]  i_issue_qk,
   input  logic              i_issue_j_rdy,
   input  logic              i_issue_k_rdy,
   input  logic              i_cdb_valid,
   input  logic [TAG_W-1:0]  i_cdb_label,
   input  logic [DATA_W-1:0] i_cdb_value,
   output logic              o_fu_run,
   output logic [DATA_W-1:0] o_fu_regx,
   output logic [DATA_W-1:0] o_fu_regy,
   output logic [OP_W-1:0]   o_fu_opcode,
   output logic [2:0]        o_fu_addr,
   output logic [TAG_W-1:0]  o_fu_label,
   input  logic              i_fu_done,
   output logic              o_illegal_op,
`ifdef RS_DIV_ZERO_TRAP_EN
   output logic              o_div0_trap,
   output logic [TAG_W-1:0]  o_div0_label,
`endif
   output logic [2:0]        o_occupancy
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [OP_W-1:0] OP_MUL = OP_W'(3'b010);
   localparam logic [OP_W-1:0] OP_DIV = OP_W'(3'b011);

   typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} state_t;

   state_t              r_state [DEPTH];
   logic [OP_W-1:0]     r_op    [DEPTH];
   logic [2:0]          r_dest  [DEPTH];
   logic [TAG_W-1:0]    r_label [DEPTH];
   logic [TAG_W-1:0]    r_qj    [DEPTH];
   logic [TAG_W-1:0]    r_qk    [DEPTH];
   logic [DATA_W-1:0]   r_vj    [DEPTH];
   logic [DATA_W-1:0]   r_vk    [DEPTH];
   logic [DEPTH-1:0]    r_jrdy, r_krdy;
   // r_older[i][j] set means entry i was issued before entry j
   logic [DEPTH-1:0]    r_older [DEPTH];

   logic                r_fu_run, r_illegal;
   logic [DATA_W-1:0]   r_fu_regx, r_fu_regy;
   logic [OP_W-1:0]     r_fu_opcode;
   logic [2:0]          r_fu_addr;
   logic [TAG_W-1:0]    r_fu_label;
`ifdef RS_DIV_ZERO_TRAP_EN
   logic                r_div0_trap;
   logic [TAG_W-1:0]    r_div0_label;
`endif

   logic [DEPTH-1:0]    w_jhit, w_khit, w_rdy, w_oldest;
   logic                w_has_free, w_busy, w_sel_vld, w_legal, w_accept;
   logic                w_dispatch, w_div0, w_iss_jrdy, w_iss_krdy;
   logic [IDX_W-1:0]    w_free_idx, w_sel_idx;
   logic [2:0]          w_occ;

   always_comb begin
      w_has_free = 1'b0;
      w_free_idx = '0;
      w_busy     = 1'b0;
      w_occ      = '0;
      w_sel_vld  = 1'b0;
      w_sel_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_rdy[i]  = (r_state[i] == S_READY);
         w_jhit[i] = i_cdb_valid && !r_jrdy[i] && (r_qj[i] == i_cdb_label);
         w_khit[i] = i_cdb_valid && !r_krdy[i] && (r_qk[i] == i_cdb_label);
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_oldest[i] = w_rdy[i];
         for (int j = 0; j < DEPTH; j++)
            if (w_rdy[j] && r_older[j][i]) w_oldest[i] = 1'b0;
         if (r_state[i] == S_EXEC) w_busy = 1'b1;
         if (r_state[i] != S_FREE) w_occ = w_occ + 3'd1;
      end
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (r_state[i] == S_FREE) begin
            w_has_free = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (w_oldest[i]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = IDX_W'(i);
         end
      end
   end

   assign w_legal    = (i_issue_op == OP_MUL) || (i_issue_op == OP_DIV);
   assign w_accept   = i_issue_valid && w_has_free && w_legal;
   // an operand broadcast in the issue cycle is captured directly
   assign w_iss_jrdy = i_issue_j_rdy || (i_cdb_valid && (i_issue_qj == i_cdb_label));
   assign w_iss_krdy = i_issue_k_rdy || (i_cdb_valid && (i_issue_qk == i_cdb_label));
   assign w_dispatch = w_sel_vld && !w_busy && !r_fu_run;
`ifdef RS_DIV_ZERO_TRAP_EN
   assign w_div0 = w_dispatch && (r_op[w_sel_idx] == OP_DIV) && (r_vk[w_sel_idx] == '0);
`else
   assign w_div0 = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i] <= S_FREE;
            r_op[i]    <= '0;
            r_dest[i]  <= '0;
            r_label[i] <= '0;
            r_qj[i]    <= '0;
            r_qk[i]    <= '0;
            r_vj[i]    <= '0;
            r_vk[i]    <= '0;
            r_older[i] <= '0;
         end
         r_jrdy      <= '0;
         r_krdy      <= '0;
         r_fu_run    <= 1'b0;
         r_fu_regx   <= '0;
         r_fu_regy   <= '0;
         r_fu_opcode <= '0;
         r_fu_addr   <= '0;
         r_fu_label  <= '0;
         r_illegal   <= 1'b0;
`ifdef RS_DIV_ZERO_TRAP_EN
         r_div0_trap  <= 1'b0;
         r_div0_label <= '0;
`endif
      end else begin
         r_illegal <= i_issue_valid && w_has_free && !w_legal;
`ifdef RS_DIV_ZERO_TRAP_EN
         r_div0_trap <= w_div0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] == S_WAIT) begin
               if (w_jhit[i]) begin
                  r_vj[i]   <= i_cdb_value;
                  r_jrdy[i] <= 1'b1;
               end
               if (w_khit[i]) begin
                  r_vk[i]   <= i_cdb_value;
                  r_krdy[i] <= 1'b1;
               end
               if ((r_jrdy[i] || w_jhit[i]) && (r_krdy[i] || w_khit[i])) r_state[i] <= S_READY;
            end
         end
         if (w_dispatch) begin
            if (w_div0) begin
               r_state[w_sel_idx] <= S_FREE;
`ifdef RS_DIV_ZERO_TRAP_EN
               r_div0_label <= r_label[w_sel_idx];
`endif
            end else begin
               r_state[w_sel_idx] <= S_EXEC;
               r_fu_run    <= 1'b1;
               r_fu_regx   <= r_vj[w_sel_idx];
               r_fu_regy   <= r_vk[w_sel_idx];
               r_fu_opcode <= r_op[w_sel_idx];
               r_fu_addr   <= r_dest[w_sel_idx];
               r_fu_label  <= r_label[w_sel_idx];
            end
         end
         if (i_fu_done && r_fu_run) begin
            r_fu_run <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
               if (r_state[i] == S_EXEC) r_state[i] <= S_FREE;
         end
         if (w_accept) begin
            r_state[w_free_idx] <= (w_iss_jrdy && w_iss_krdy) ? S_READY : S_WAIT;
            r_op[w_free_idx]    <= i_issue_op;
            r_dest[w_free_idx]  <= i_issue_dest;
            r_label[w_free_idx] <= i_issue_label;
            r_qj[w_free_idx]    <= i_issue_qj;
            r_qk[w_free_idx]    <= i_issue_qk;
            r_vj[w_free_idx]    <= i_issue_j_rdy ? i_issue_vj : i_cdb_value;
            r_vk[w_free_idx]    <= i_issue_k_rdy ? i_issue_vk : i_cdb_value;
            r_jrdy[w_free_idx]  <= w_iss_jrdy;
            r_krdy[w_free_idx]  <= w_iss_krdy;
            for (int j = 0; j < DEPTH; j++)
               r_older[j][w_free_idx] <= (r_state[j] != S_FREE);
            r_older[w_free_idx] <= '0;
         end
      end
   end

   assign o_issue_ready = w_has_free;
   assign o_occupancy   = w_occ;
   assign o_fu_run      = r_fu_run;
   assign o_fu_regx     = r_fu_regx;
   assign o_fu_regy     = r_fu_regy;
   assign o_fu_opcode   = r_fu_opcode;
   assign o_fu_addr     = r_fu_addr;
   assign o_fu_label    = r_fu_label;
   assign o_illegal_op  = r_illegal;
`ifdef RS_DIV_ZERO_TRAP_EN
   assign o_div0_trap   = r_div0_trap;
   assign o_div0_label  = r_div0_label;
`endif
endmodule

// File: tb/tb_rs_mul_div.sv
// Bench for rs_mul_div: directed scenarios plus a randomized run scored against an issue-order/ready-time model.
module tb_rs_mul_div;
   localparam int DW = 9, TW = 3, OW = 3, DEPTH = 2, NOPS = 40;

   logic clk = 1'b0, reset = 1'b0;
   logic issue_valid, issue_ready, j_rdy, k_rdy, cdb_valid, fu_run, fu_done, illegal_op;
   logic [OW-1:0] issue_op, fu_opcode;
   logic [2:0]    issue_dest, fu_addr, occupancy;
   logic [TW-1:0] issue_label, qj, qk, cdb_label, fu_label;
   logic [DW-1:0] vj, vk, cdb_value, fu_regx, fu_regy;
`ifdef RS_DIV_ZERO_TRAP_EN
   logic div0_trap;
   logic [TW-1:0] div0_label;
`endif

   int n_chk = 0, n_pass = 0, cyc = 0;

   rs_mul_div #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
      .i_issue_op(issue_op), .i_issue_dest(issue_dest), .i_issue_label(issue_label),
      .i_issue_vj(vj), .i_issue_vk(vk), .i_issue_qj(qj), .i_issue_qk(qk),
      .i_issue_j_rdy(j_rdy), .i_issue_k_rdy(k_rdy), .i_cdb_valid(cdb_valid),
      .i_cdb_label(cdb_label), .i_cdb_value(cdb_value), .o_fu_run(fu_run),
      .o_fu_regx(fu_regx), .o_fu_regy(fu_regy), .o_fu_opcode(fu_opcode),
      .o_fu_addr(fu_addr), .o_fu_label(fu_label), .i_fu_done(fu_done),
      .o_illegal_op(illegal_op),
`ifdef RS_DIV_ZERO_TRAP_EN
      .o_div0_trap(div0_trap), .o_div0_label(div0_label),
`endif
      .o_occupancy(occupancy));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1; cyc++;
   endtask

   task automatic idle();
      issue_valid = 0; issue_op = '0; issue_dest = '0; issue_label = '0;
      vj = '0; vk = '0; qj = '0; qk = '0; j_rdy = 0; k_rdy = 0;
      cdb_valid = 0; cdb_label = '0; cdb_value = '0; fu_done = 0;
   endtask

   task automatic drive_issue(input logic [2:0] op, dest, label, input logic [8:0] a, b,
                              input logic [2:0] ta, tb, input bit ra, rb);
      issue_valid = 1; issue_op = op; issue_dest = dest; issue_label = label;
      vj = a; vk = b; qj = ta; qk = tb; j_rdy = ra; k_rdy = rb;
   endtask

   function automatic bit is_legal(input logic [2:0] op);
      return (op == 3'b010) || (op == 3'b011);
   endfunction

   function automatic logic [TW-1:0] pick_tag(input logic [TW-1:0] used[$]);
      int s;
      bit hit;
      logic [TW-1:0] t;
      s = $urandom_range(0, 7);
      for (int n = 0; n < 8; n++) begin
         t = TW'((s + n) % 8);
         hit = 0;
         foreach (used[k]) if (used[k] == t) hit = 1;
         if (!hit) return t;
      end
      return '0;
   endfunction

   task automatic test_reset();
      reset = 1; idle(); tick(); tick();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL rst_run: got %b want 0", fu_run); else n_pass++;
      n_chk++; if ({fu_regx, fu_regy, fu_opcode, fu_addr, fu_label} !== '0)
         $display("FAIL rst_fu_bus: got %h want 0", {fu_regx, fu_regy, fu_opcode, fu_addr, fu_label}); else n_pass++;
      n_chk++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal_op); else n_pass++;
      n_chk++; if (occupancy !== 3'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else n_pass++;
      n_chk++; if (issue_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", issue_ready); else n_pass++;
      reset = 0;
   endtask

   task automatic test_mul();
      drive_issue(3'b010, 3'd2, 3'd1, 9'd5, 9'd7, 3'd0, 3'd0, 1, 1); tick(); idle();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL mul_run_early: got %b want 0", fu_run); else n_pass++;
      n_chk++; if (occupancy !== 3'd1) $display("FAIL mul_occ: got %0d want 1", occupancy); else n_pass++;
      tick();
      n_chk++; if (fu_run !== 1'b1) $display("FAIL mul_run: got %b want 1", fu_run); else n_pass++;
      n_chk++; if ({fu_regx, fu_regy, fu_opcode, fu_label, fu_addr} !== {9'd5, 9'd7, 3'b010, 3'd1, 3'd2})
         $display("FAIL mul_bus: got x=%0d y=%0d op=%b lbl=%0d addr=%0d want 5 7 010 1 2",
                  fu_regx, fu_regy, fu_opcode, fu_label, fu_addr); else n_pass++;
      repeat (3) tick();
      n_chk++; if (fu_run !== 1'b1 || fu_regx !== 9'd5 || fu_regy !== 9'd7)
         $display("FAIL mul_hold: got run=%b x=%0d y=%0d want 1 5 7", fu_run, fu_regx, fu_regy); else n_pass++;
      fu_done = 1; tick(); idle();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL mul_done_run: got %b want 0", fu_run); else n_pass++;
      n_chk++; if (occupancy !== 3'd0) $display("FAIL mul_done_occ: got %0d want 0", occupancy); else n_pass++;
      tick();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL mul_idle_run: got %b want 0", fu_run); else n_pass++;
   endtask

   task automatic test_div_wake();
      drive_issue(3'b011, 3'd5, 3'd2, 9'd0, 9'd4, 3'd3, 3'd0, 0, 1); tick(); idle();
      cdb_valid = 1; cdb_label = 3'd4; cdb_value = 9'd99; tick(); idle(); tick();
      n_chk++; if (fu_run !== 1'b0 || occupancy !== 3'd1)
         $display("FAIL div_wait: got run=%b occ=%0d want 0 1", fu_run, occupancy); else n_pass++;
      cdb_valid = 1; cdb_label = 3'd3; cdb_value = 9'd20; tick(); idle();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL div_wake_same: got %b want 0", fu_run); else n_pass++;
      tick();
      n_chk++; if ({fu_run, fu_regx, fu_regy, fu_opcode} !== {1'b1, 9'd20, 9'd4, 3'b011})
         $display("FAIL div_wake_bus: got run=%b x=%0d y=%0d op=%b want 1 20 4 011",
                  fu_run, fu_regx, fu_regy, fu_opcode); else n_pass++;
      fu_done = 1; tick(); idle();
   endtask

   task automatic test_forward();
      drive_issue(3'b010, 3'd1, 3'd3, 9'd0, 9'd3, 3'd5, 3'd0, 0, 1);
      cdb_valid = 1; cdb_label = 3'd5; cdb_value = 9'd9; tick(); idle(); tick();
      n_chk++; if (fu_run !== 1'b1 || fu_regx !== 9'd9 || fu_regy !== 9'd3)
         $display("FAIL fwd_bus: got run=%b x=%0d y=%0d want 1 9 3", fu_run, fu_regx, fu_regy); else n_pass++;
      fu_done = 1; tick(); idle();
   endtask

   task automatic test_fill();
      drive_issue(3'b011, 3'd1, 3'd1, 9'd0, 9'd6, 3'd4, 3'd0, 0, 1); tick();
      drive_issue(3'b010, 3'd2, 3'd2, 9'd7, 9'd0, 3'd0, 3'd4, 1, 0); tick(); idle();
      n_chk++; if (occupancy !== 3'd2 || issue_ready !== 1'b0 || fu_run !== 1'b0)
         $display("FAIL fill_full: got occ=%0d rdy=%b run=%b want 2 0 0", occupancy, issue_ready, fu_run); else n_pass++;
      drive_issue(3'b010, 3'd3, 3'd3, 9'd1, 9'd1, 3'd0, 3'd0, 1, 1); tick(); idle();
      n_chk++; if (occupancy !== 3'd2 || illegal_op !== 1'b0)
         $display("FAIL fill_third: got occ=%0d ill=%b want 2 0", occupancy, illegal_op); else n_pass++;
      cdb_valid = 1; cdb_label = 3'd4; cdb_value = 9'd8; tick(); idle(); tick();
      n_chk++; if ({fu_run, fu_label, fu_regx, fu_regy} !== {1'b1, 3'd1, 9'd8, 9'd6})
         $display("FAIL fill_oldest: got run=%b lbl=%0d x=%0d y=%0d want 1 1 8 6",
                  fu_run, fu_label, fu_regx, fu_regy); else n_pass++;
      drive_issue(3'b010, 3'd3, 3'd3, 9'd1, 9'd1, 3'd0, 3'd0, 1, 1); fu_done = 1; tick(); idle();
      n_chk++; if (fu_run !== 1'b0 || occupancy !== 3'd1 || issue_ready !== 1'b1)
         $display("FAIL fill_free: got run=%b occ=%0d rdy=%b want 0 1 1", fu_run, occupancy, issue_ready); else n_pass++;
      tick();
      n_chk++; if ({fu_run, fu_label, fu_regx, fu_regy} !== {1'b1, 3'd2, 9'd7, 9'd8})
         $display("FAIL fill_second: got run=%b lbl=%0d x=%0d y=%0d want 1 2 7 8",
                  fu_run, fu_label, fu_regx, fu_regy); else n_pass++;
      fu_done = 1; tick(); idle();
      n_chk++; if (occupancy !== 3'd0) $display("FAIL fill_empty: got %0d want 0", occupancy); else n_pass++;
   endtask

   task automatic test_illegal();
      drive_issue(3'b000, 3'd1, 3'd1, 9'd1, 9'd1, 3'd0, 3'd0, 1, 1); tick(); idle();
      n_chk++; if (illegal_op !== 1'b1 || occupancy !== 3'd0)
         $display("FAIL ill_pulse: got ill=%b occ=%0d want 1 0", illegal_op, occupancy); else n_pass++;
      tick();
      n_chk++; if (illegal_op !== 1'b0 || fu_run !== 1'b0)
         $display("FAIL ill_once: got ill=%b run=%b want 0 0", illegal_op, fu_run); else n_pass++;
      drive_issue(3'b111, 3'd1, 3'd1, 9'd1, 9'd1, 3'd0, 3'd0, 1, 1); tick(); idle();
      n_chk++; if (illegal_op !== 1'b1) $display("FAIL ill_111: got %b want 1", illegal_op); else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive_issue(3'b010, 3'd1, 3'd4, 9'd11, 9'd12, 3'd0, 3'd0, 1, 1); tick();
      drive_issue(3'b011, 3'd2, 3'd5, 9'd0, 9'd1, 3'd6, 3'd0, 0, 1); tick(); idle();
      n_chk++; if (fu_run !== 1'b1 || occupancy !== 3'd2)
         $display("FAIL rmid_pre: got run=%b occ=%0d want 1 2", fu_run, occupancy); else n_pass++;
      reset = 1; tick(); reset = 0;
      n_chk++; if (fu_run !== 1'b0 || occupancy !== 3'd0 || fu_regx !== '0)
         $display("FAIL rmid_post: got run=%b occ=%0d x=%0d want 0 0 0", fu_run, occupancy, fu_regx); else n_pass++;
      tick();
      n_chk++; if (fu_run !== 1'b0) $display("FAIL rmid_stay: got %b want 0", fu_run); else n_pass++;
   endtask

`ifdef RS_DIV_ZERO_TRAP_EN
   task automatic test_div0();
      drive_issue(3'b011, 3'd1, 3'd6, 9'd50, 9'd0, 3'd0, 3'd0, 1, 1); tick(); idle();
      n_chk++; if (div0_trap !== 1'b0) $display("FAIL d0_early: got %b want 0", div0_trap); else n_pass++;
      tick();
      n_chk++; if ({div0_trap, div0_label, fu_run, occupancy} !== {1'b1, 3'd6, 1'b0, 3'd0})
         $display("FAIL d0_trap: got trap=%b lbl=%0d run=%b occ=%0d want 1 6 0 0",
                  div0_trap, div0_label, fu_run, occupancy); else n_pass++;
      tick();
      n_chk++; if (div0_trap !== 1'b0 || fu_run !== 1'b0)
         $display("FAIL d0_after: got trap=%b run=%b want 0 0", div0_trap, fu_run); else n_pass++;
   endtask
`else
   task automatic test_div0();
      drive_issue(3'b011, 3'd1, 3'd6, 9'd50, 9'd0, 3'd0, 3'd0, 1, 1); tick(); idle(); tick();
      n_chk++; if ({fu_run, fu_regy, fu_label} !== {1'b1, 9'd0, 3'd6})
         $display("FAIL d0_plain: got run=%b y=%0d lbl=%0d want 1 0 6", fu_run, fu_regy, fu_label); else n_pass++;
      fu_done = 1; tick(); idle();
   endtask
`endif

   typedef struct {
      logic [OW-1:0] op;
      logic [DW-1:0] a, b;
      logic [2:0]    dest;
      logic [TW-1:0] label, ta, tb;
      bit            jm, km, disp;
      int            rdy_edge;
   } op_t;

   // Model: ops in issue order; an op becomes eligible the edge its last operand arrives and
   // dispatches in the cycle after, if the FU was idle, choosing the earliest-issued eligible op.
   task automatic test_random();
      op_t mq[$];
      op_t e;
      logic [TW-1:0] used[$];
      int n_iss, occ, lat, cur, cand, budget;
      bit mrun, prev_run, exp_ill, acc, cdb_j, cdb_k;
      reset = 1; idle(); tick(); reset = 0;
      n_iss = 0; occ = 0; lat = 0; cur = 0; budget = 0; mrun = 0;
      while (!(n_iss == NOPS && occ == 0) && budget < 4000) begin
         budget++;
         idle();
         used.delete();
         foreach (mq[i]) if (!mq[i].disp) begin
            if (mq[i].jm) used.push_back(mq[i].ta);
            if (mq[i].km) used.push_back(mq[i].tb);
         end
         if ($urandom_range(0, 2) == 0) begin
            cdb_valid = 1; cdb_value = DW'($urandom_range(1, 511));
            if (used.size() > 0 && $urandom_range(0, 3) != 0) cdb_label = used[$urandom_range(0, used.size()-1)];
            else cdb_label = pick_tag(used);
            used.push_back(cdb_label);
         end
         if (n_iss < NOPS && $urandom_range(0, 1) == 0) begin
            issue_valid = 1;
            if ($urandom_range(0, 7) == 0) begin
               cand = $urandom_range(0, 5);
               issue_op = OW'((cand < 2) ? cand : cand + 2);
            end else issue_op = $urandom_range(0, 1) ? 3'b010 : 3'b011;
            issue_dest = 3'($urandom_range(0, 7)); issue_label = TW'($urandom_range(0, 7));
            vj = DW'($urandom_range(1, 511)); vk = DW'($urandom_range(1, 511));
            j_rdy = 1'($urandom_range(0, 1)); k_rdy = 1'($urandom_range(0, 1));
            qj = pick_tag(used);
            if ($urandom_range(0, 3) == 0) qk = qj;
            else begin used.push_back(qj); qk = pick_tag(used); end
         end
         if (mrun) begin
            if (lat == 0) fu_done = 1; else lat--;
         end else if ($urandom_range(0, 7) == 0) fu_done = 1;
         prev_run = mrun;
         exp_ill = issue_valid && (occ < DEPTH) && !is_legal(issue_op);
         acc = issue_valid && (occ < DEPTH) && is_legal(issue_op);
         tick();
         if (cdb_valid) foreach (mq[i]) if (!mq[i].disp && (mq[i].jm || mq[i].km)) begin
            if (mq[i].jm && mq[i].ta == cdb_label) begin mq[i].a = cdb_value; mq[i].jm = 0; end
            if (mq[i].km && mq[i].tb == cdb_label) begin mq[i].b = cdb_value; mq[i].km = 0; end
            if (!mq[i].jm && !mq[i].km) mq[i].rdy_edge = cyc;
         end
         if (acc) begin
            cdb_j = cdb_valid && (cdb_label == qj);
            cdb_k = cdb_valid && (cdb_label == qk);
            e.op = issue_op; e.dest = issue_dest; e.label = issue_label; e.ta = qj; e.tb = qk;
            e.jm = !j_rdy && !cdb_j; e.km = !k_rdy && !cdb_k;
            e.a = j_rdy ? vj : cdb_value; e.b = k_rdy ? vk : cdb_value;
            e.disp = 0; e.rdy_edge = (!e.jm && !e.km) ? cyc : -1;
            mq.push_back(e); n_iss++; occ++;
         end
         if (fu_done && prev_run) occ--;
         if (prev_run) mrun = !fu_done;
         else begin
            cand = -1;
            foreach (mq[i]) if (cand < 0 && !mq[i].disp && mq[i].rdy_edge >= 0 && mq[i].rdy_edge <= cyc-1) cand = i;
            mrun = (cand >= 0);
            if (mrun) begin mq[cand].disp = 1; cur = cand; lat = $urandom_range(0, 4); end
         end
         n_chk++; if (fu_run !== mrun) $display("FAIL rnd_run@%0d: got %b want %b", cyc, fu_run, mrun); else n_pass++;
         if (mrun) begin
            n_chk++;
            if ({fu_regx, fu_regy, fu_opcode, fu_addr, fu_label} !== {mq[cur].a, mq[cur].b, mq[cur].op, mq[cur].dest, mq[cur].label})
               $display("FAIL rnd_bus@%0d: got x=%0d y=%0d op=%b a=%0d l=%0d want %0d %0d %b %0d %0d", cyc,
                        fu_regx, fu_regy, fu_opcode, fu_addr, fu_label,
                        mq[cur].a, mq[cur].b, mq[cur].op, mq[cur].dest, mq[cur].label);
            else n_pass++;
         end
         n_chk++; if (occupancy !== 3'(occ) || issue_ready !== (occ < DEPTH) || illegal_op !== exp_ill)
            $display("FAIL rnd_status@%0d: got occ=%0d rdy=%b ill=%b want %0d %b %b", cyc,
                     occupancy, issue_ready, illegal_op, occ, occ < DEPTH, exp_ill); else n_pass++;
      end
      n_chk++; if (budget >= 4000) $display("FAIL rnd_budget: got %0d issued occ=%0d want %0d drained", n_iss, occ, NOPS);
      else n_pass++;
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_mul();
      test_div_wake();
      test_forward();
      test_fill();
      test_illegal();
      test_reset_mid();
      test_div0();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
